micro_sequencer: RTL

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: three-state FSM driving the control-store address,
// with dispatch, conditional branch, one-level call/return and sticky error.
module micro_sequencer #(
  parameter int AW         = 7,
  parameter int DEPTH      = 128,
  parameter int FETCH_ADDR = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          mem_wait,
  input  logic [15:0]   map_addr,
  input  logic          z_flag,
  input  logic [2:0]    mi_seq,
  input  logic [AW-1:0] mi_addr,
  output logic [AW-1:0] upc,
  output logic          busy,
  output logic          halted,
  output logic          err,
  output logic          disp_stb,
  output logic [15:0]   instr_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_e;

  localparam logic [2:0] SQ_INC  = 3'd0;
  localparam logic [2:0] SQ_JMP  = 3'd1;
  localparam logic [2:0] SQ_DISP = 3'd2;
  localparam logic [2:0] SQ_BZ   = 3'd3;
  localparam logic [2:0] SQ_BNZ  = 3'd4;
  localparam logic [2:0] SQ_HALT = 3'd5;
  localparam logic [2:0] SQ_CALL = 3'd6;
  localparam logic [2:0] SQ_RET  = 3'd7;

  localparam logic [AW-1:0] FETCH = AW'(FETCH_ADDR);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] upc_q, upc_d;
  logic [AW-1:0] ret_q, ret_d;
  logic          ret_vld_q, ret_vld_d;
  logic          err_q, err_d;
  logic          stb_q, stb_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          halt_q, halt_d;

  logic [AW-1:0] upc_inc;
  logic          at_end;
  logic          disp_ok;
  logic [AW-1:0] seq_upc;
  logic          seq_halt;
  logic          seq_err;
  logic          seq_disp;
  logic          seq_call;
  logic          seq_ret;

  assign upc_inc = upc_q + AW'(1);
  assign at_end  = (upc_q == LAST);
  assign disp_ok = (32'(map_addr) < DEPTH);

  // Outcome of the current microword, used only when RUN and not stalled
  always_comb begin
    seq_upc  = upc_q;
    seq_halt = 1'b0;
    seq_err  = 1'b0;
    seq_disp = 1'b0;
    seq_call = 1'b0;
    seq_ret  = 1'b0;
    unique case (mi_seq)
      SQ_INC: begin
        if (at_end) begin
          seq_halt = 1'b1;
          seq_err  = 1'b1;
        end else begin
          seq_upc = upc_inc;
        end
      end
      SQ_JMP: seq_upc = mi_addr;
      SQ_DISP: begin
        if (disp_ok) begin
          seq_upc  = AW'(map_addr);
          seq_disp = 1'b1;
        end else begin
          seq_halt = 1'b1;
          seq_err  = 1'b1;
        end
      end
      SQ_BZ, SQ_BNZ: begin
        if (z_flag == (mi_seq == SQ_BZ)) begin
          seq_upc = mi_addr;
        end else if (at_end) begin
          seq_halt = 1'b1;
          seq_err  = 1'b1;
        end else begin
          seq_upc = upc_inc;
        end
      end
      SQ_HALT: seq_halt = 1'b1;
      SQ_CALL: begin
        if (ret_vld_q) begin
          seq_halt = 1'b1;
          seq_err  = 1'b1;
        end else begin
          seq_upc  = mi_addr;
          seq_call = 1'b1;
        end
      end
      SQ_RET: begin
        if (ret_vld_q) begin
          seq_upc = ret_q;
          seq_ret = 1'b1;
        end else begin
          seq_halt = 1'b1;
          seq_err  = 1'b1;
        end
      end
      default: seq_halt = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (!mem_wait && seq_halt) state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    upc_d     = upc_q;
    ret_d     = ret_q;
    ret_vld_d = ret_vld_q;
    err_d     = err_q;
    stb_d     = 1'b0;
    cnt_d     = cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (!mem_wait) begin
          upc_d = seq_upc;
          err_d = err_q | seq_err;
          if (seq_disp) begin
            stb_d = 1'b1;
            cnt_d = cnt_q + 16'd1;
          end
          if (seq_call) begin
            ret_d     = upc_inc;
            ret_vld_d = 1'b1;
          end
          if (seq_ret) ret_vld_d = 1'b0;
        end
      end
      default: begin
        if (start) begin
          upc_d     = FETCH;
          err_d     = 1'b0;
          ret_d     = '0;
          ret_vld_d = 1'b0;
        end
      end
    endcase
    busy_d = (state_d == S_RUN);
    halt_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      upc_q     <= FETCH;
      ret_q     <= '0;
      ret_vld_q <= 1'b0;
      err_q     <= 1'b0;
      stb_q     <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      upc_q     <= upc_d;
      ret_q     <= ret_d;
      ret_vld_q <= ret_vld_d;
      err_q     <= err_d;
      stb_q     <= stb_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      halt_q    <= halt_d;
    end
  end

  assign upc       = upc_q;
  assign busy      = busy_q;
  assign halted    = halt_q;
  assign err       = err_q;
  assign disp_stb  = stb_q;
  assign instr_cnt = cnt_q;

endmodule
